// File: rtl/cosim_pkg.sv
// Shared definitions for both ends of the cosim command link:
// opcodes, frame lengths, FSM state encodings and the UART bit-period helper.
package cosim_pkg;

   typedef enum logic [2:0] {
      OP_SET_DEPTH = 3'd1,
      OP_PUSH      = 3'd2,
      OP_START     = 3'd3,
      OP_READ_PMU  = 3'd4
   } cosim_op_e;

   typedef enum logic {
      ST_IDLE,
      ST_SEND
   } frame_state_e;

   typedef enum logic [1:0] {
      SER_IDLE,
      SER_START,
      SER_DATA,
      SER_STOP
   } ser_state_e;

   localparam int MAX_FRAME_LEN = 5;

   // Frame length in bytes; zero marks an illegal opcode.
   function automatic logic [2:0] frame_len(input logic [2:0] op);
      case (op)
         OP_SET_DEPTH: frame_len = 3'd2;
         OP_PUSH:      frame_len = 3'd5;
         OP_START:     frame_len = 3'd1;
         OP_READ_PMU:  frame_len = 3'd3;
         default:      frame_len = 3'd0;
      endcase
   endfunction

   function automatic int uart_div(input int clk_freq, input int baud_rate);
      return clk_freq / baud_rate;
   endfunction

endpackage

// File: rtl/cosim_cmd_sender_if.sv
// Command request port of the cosim command sender: valid/ready plus all
// command fields. The sequencer drives through master, the sender is slave.
interface cosim_cmd_sender_if #(
   parameter int CORE_COUNT   = 16,
   parameter int AXI_ID_WIDTH = 5
);
   localparam int CORE_W = (CORE_COUNT > 1) ? $clog2(CORE_COUNT) : 1;

   logic                    cmd_valid_i;
   logic                    cmd_ready_o;
   logic [2:0]              cmd_op_i;
   logic [CORE_W-1:0]       cmd_core_i;
   logic [AXI_ID_WIDTH-1:0] cmd_id_i;
   logic                    cmd_write_i;
   logic [7:0]              cmd_axlen_i;
   logic [7:0]              cmd_depth_i;
   logic [4:0]              cmd_pmu_addr_i;

   modport master (
      output cmd_valid_i, cmd_op_i, cmd_core_i, cmd_id_i, cmd_write_i,
             cmd_axlen_i, cmd_depth_i, cmd_pmu_addr_i,
      input  cmd_ready_o
   );

   modport slave (
      input  cmd_valid_i, cmd_op_i, cmd_core_i, cmd_id_i, cmd_write_i,
             cmd_axlen_i, cmd_depth_i, cmd_pmu_addr_i,
      output cmd_ready_o
   );

endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer. A start pulse in IDLE, or in the last cycle of STOP,
// launches a byte; done_o marks the final cycle of the stop bit.
module uart_tx_byte
   import cosim_pkg::*;
#(
   parameter int N = 5208
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [7:0] byte_i,
   input  logic       start_i,
   output logic       done_o,
   output logic       tx_o
);
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

   ser_state_e     state_reg, state_next;
   logic [CW-1:0]  cnt_reg, cnt_next;
   logic [2:0]     bit_reg, bit_next;
   logic [7:0]     shift_reg, shift_next;
   logic           tx_reg, tx_next;
   logic           bit_end;

   assign bit_end  = (state_reg != SER_IDLE) && (cnt_reg == CNT_LAST);
   assign cnt_next = ((state_reg == SER_IDLE) || bit_end) ? '0 : cnt_reg + CW'(1);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg <= SER_IDLE;
         cnt_reg   <= '0;
         bit_reg   <= '0;
         shift_reg <= '0;
         tx_reg    <= 1'b1;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         bit_reg   <= bit_next;
         shift_reg <= shift_next;
         tx_reg    <= tx_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      bit_next   = bit_reg;
      shift_next = shift_reg;
      case (state_reg)
         SER_IDLE: begin
            if (start_i) begin
               state_next = SER_START;
               shift_next = byte_i;
            end
         end
         SER_START: begin
            if (bit_end) begin
               state_next = SER_DATA;
               bit_next   = 3'd0;
            end
         end
         SER_DATA: begin
            if (bit_end) begin
               shift_next = {1'b0, shift_reg[7:1]};
               bit_next   = bit_reg + 3'd1;
               if (bit_reg == 3'd7) state_next = SER_STOP;
            end
         end
         SER_STOP: begin
            // Chaining straight into the next START keeps bytes gap-free.
            if (bit_end) begin
               if (start_i) begin
                  state_next = SER_START;
                  shift_next = byte_i;
               end else begin
                  state_next = SER_IDLE;
               end
            end
         end
         default: state_next = SER_IDLE;
      endcase
   end

   always_comb begin
      done_o = (state_reg == SER_STOP) && bit_end;
      case (state_next)
         SER_START: tx_next = 1'b0;
         SER_DATA:  tx_next = shift_next[0];
         default:   tx_next = 1'b1;
      endcase
   end

   assign tx_o = tx_reg;

endmodule

// File: rtl/cosim_cmd_sender.sv
// Host-side cosim command transmitter: latches a command into a frame buffer
// on handshake and streams its bytes through the UART byte serializer.
module cosim_cmd_sender
   import cosim_pkg::*;
#(
   parameter int CORE_COUNT   = 16,
   parameter int AXI_ID_WIDTH = 5,
   parameter int BAUD_RATE    = 9_600,
   parameter int CLK_FREQ     = 50_000_000
) (
   input  logic                clk_i,
   input  logic                rst_i,
   cosim_cmd_sender_if.slave   cmd,
   output logic                tx_o,
   output logic                busy_o,
   output logic                err_o,
   output logic [15:0]         frames_sent_o
);
   localparam int N      = uart_div(CLK_FREQ, BAUD_RATE);
   localparam int CORE_W = (CORE_COUNT > 1) ? $clog2(CORE_COUNT) : 1;

   frame_state_e             state_reg, state_next;
   logic [7:0]               frame_reg [0:MAX_FRAME_LEN-1];
   logic [7:0]               frame_in  [0:MAX_FRAME_LEN-1];
   logic [2:0]               idx_reg, len_reg;
   logic [15:0]              frames_sent_reg;
   logic                     err_reg;
   logic [CORE_W-1:0]        core_v;
   logic [AXI_ID_WIDTH-1:0]  id_v;
   logic [2:0]               op_len;
   logic                     accept, start_frame, ser_start, ser_done;
   logic                     byte_done, issue_next, frame_done;
   logic                     ready_int, busy_int;
   logic [7:0]               ser_byte;

   assign core_v      = cmd.cmd_core_i;
   assign id_v        = cmd.cmd_id_i;
   assign op_len      = frame_len(cmd.cmd_op_i);
   assign accept      = cmd.cmd_valid_i && ready_int;
   assign start_frame = accept && (op_len != 3'd0);
   assign byte_done   = (state_reg == ST_SEND) && ser_done;
   assign issue_next  = byte_done && (idx_reg != len_reg);
   assign frame_done  = byte_done && (idx_reg == len_reg);

   // Byte 0 goes straight from the opcode input so the start bit lands on T+1.
   assign ser_start = start_frame || issue_next;
   assign ser_byte  = start_frame ? {5'd0, cmd.cmd_op_i} : frame_reg[idx_reg];

   always_comb begin
      for (int i = 0; i < MAX_FRAME_LEN; i++) frame_in[i] = 8'h00;
      frame_in[0] = {5'd0, cmd.cmd_op_i};
      case (cmd.cmd_op_i)
         OP_SET_DEPTH: frame_in[1] = cmd.cmd_depth_i;
         OP_PUSH: begin
            frame_in[1] = 8'(core_v);
            frame_in[2] = 8'(id_v);
            frame_in[3] = {7'd0, cmd.cmd_write_i};
            frame_in[4] = cmd.cmd_axlen_i;
         end
         OP_READ_PMU: begin
            frame_in[1] = 8'(core_v);
            frame_in[2] = {3'd0, cmd.cmd_pmu_addr_i};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg       <= ST_IDLE;
         idx_reg         <= '0;
         len_reg         <= '0;
         frames_sent_reg <= '0;
         err_reg         <= 1'b0;
         for (int i = 0; i < MAX_FRAME_LEN; i++) frame_reg[i] <= 8'h00;
      end else begin
         state_reg <= state_next;
         err_reg   <= accept && (op_len == 3'd0);
         if (start_frame) begin
            idx_reg <= 3'd1;
            len_reg <= op_len;
            for (int i = 0; i < MAX_FRAME_LEN; i++) frame_reg[i] <= frame_in[i];
         end else if (issue_next) begin
            idx_reg <= idx_reg + 3'd1;
         end
         if (frame_done) frames_sent_reg <= frames_sent_reg + 16'd1;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (start_frame) state_next = ST_SEND;
         ST_SEND: if (frame_done)  state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      ready_int = (state_reg == ST_IDLE);
      busy_int  = (state_reg == ST_SEND);
   end

   assign cmd.cmd_ready_o = ready_int;
   assign busy_o          = busy_int;
   assign err_o           = err_reg;
   assign frames_sent_o   = frames_sent_reg;

   uart_tx_byte #(.N(N)) u_tx (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .byte_i  (ser_byte),
      .start_i (ser_start),
      .done_o  (ser_done),
      .tx_o    (tx_o)
   );

endmodule

// File: doc/cosim_cmd_sender.md
# cosim_cmd_sender

Hardware host-side command transmitter for the cosimulation UART link. Accepts configuration/readback commands from a local sequencer over a valid/ready port, encodes them into the cosim command byte format, and serializes each byte as 8N1 UART onto a line that feeds the `rx_i` of the cosim top. It is the initiator end of the command channel. It is used for on-FPGA self-test and for simulation benches that drive the link without a PC.

## Interface
- `CORE_COUNT`, 16, number of mesh cores addressable by a command
- `AXI_ID_WIDTH`, 5, width of the AXI ID field carried in PUSH commands
- `BAUD_RATE`, 9_600, UART bit rate
- `CLK_FREQ`, 50_000_000, `clk_i` frequency in Hz
- `clk_i`  in  1  single clock for all logic
- `rst_i`  in  1  reset, synchronous, active-high
- `cmd_valid_i`  in  1  command request
- `cmd_ready_o`  out  1  command accepted when `cmd_valid_i & cmd_ready_o`
- `cmd_op_i`  in  3  opcode (see Operation)
- `cmd_core_i`  in  $clog2(CORE_COUNT)  target core index
- `cmd_id_i`  in  AXI_ID_WIDTH  AXI ID for PUSH
- `cmd_write_i`  in  1  write flag for PUSH
- `cmd_axlen_i`  in  8  burst length for PUSH
- `cmd_depth_i`  in  8  request depth for SET_DEPTH
- `cmd_pmu_addr_i`  in  5  PMU register index for READ_PMU
- `tx_o`  out  1  UART line, idle high
- `busy_o`  out  1  frame in progress
- `err_o`  out  1  one-cycle pulse: illegal opcode dropped
- `frames_sent_o`  out  16  count of completed frames, wraps

## Operation
- Opcodes and frame bytes (byte 0 = opcode, zero-extended fields, LSB-aligned):
  - 3'd1 SET_DEPTH: 0x01, depth (2 bytes)
  - 3'd2 PUSH: 0x02, core, id, write, axlen (5 bytes)
  - 3'd3 START: 0x03 (1 byte)
  - 3'd4 READ_PMU: 0x04, core, pmu_addr (3 bytes)
  - Any other opcode is illegal.
- Top FSM states: IDLE, SEND, with transitions:
  - IDLE: `cmd_ready_o`=1. On a handshake with a legal opcode, latch all fields into a 5-byte frame buffer and a length count, then go to SEND.
  - IDLE with an illegal opcode: the handshake still completes, `err_o` pulses next cycle, and the FSM stays in IDLE.
  - SEND: `cmd_ready_o`=0 and `busy_o`=1. Bytes are issued in order to the byte serializer. After the last byte's stop bit completes, `frames_sent_o` increments (0xFFFF→0x0000) and the FSM returns to IDLE.
- Byte serializer states: IDLE, START, DATA(8 bits, LSB first), STOP. Each state lasts one bit period. The next byte's START follows the previous STOP with no idle gap.
- Bit period `N = CLK_FREQ / BAUD_RATE` (integer, truncated). The divider counter runs only outside IDLE and reloads at each bit boundary.
- Input fields are sampled only at the handshake. Changes afterwards have no effect.
- Reset mid-frame: the frame is abandoned. The next edge with `rst_i` high forces `tx_o`=1 and the FSM to IDLE, and clears the counters.

## Timing
- Reset values: `tx_o`=1, `cmd_ready_o`=1, `busy_o`=0, `err_o`=0, `frames_sent_o`=0.
- Handshake at cycle T: `tx_o` goes low (start bit) at T+1 and `busy_o`=1 at T+1.
- A frame of k bytes occupies `tx_o` for exactly 10·k·N cycles, from T+1 through T+10kN.
- `cmd_ready_o` returns to 1 at T+1+10kN, and `frames_sent_o` updates in that same cycle.
- Back-to-back: a handshake at T+1+10kN starts the next start bit at T+2+10kN, so there is one idle-high cycle between frames.
- `err_o` is high for exactly one cycle, T+1. There is no line activity.

## Structure
- Shared package `cosim_pkg` holds:
  - the opcode enum `cosim_op_e`
  - the `FRAME_LEN` lookup function
  - the bit-period function `uart_div(CLK_FREQ, BAUD_RATE)`
- The same package is used by the receiving end.
- Sub-module `uart_tx_byte` is the byte serializer:
  - ports: byte in, start pulse, done pulse, `tx_o`, `N` as parameter
  - `cosim_cmd_sender` owns the frame FSM and buffer.

## Test plan
All scenarios use CLK_FREQ=1000 and BAUD_RATE=100, so N=10.
- Reset: hold `rst_i` 3 cycles → `tx_o`=1, `cmd_ready_o`=1, `frames_sent_o`=0.
- START: op=3 → `tx_o` pattern 0,1,1,0,0,0,0,0,0,1 (10 cycles each), i.e. byte 0x03. `cmd_ready_o` is back high 101 cycles after the handshake, and `frames_sent_o`=1.
- PUSH: core=5, id=0x1F, write=1, axlen=0x0F → a UART decoder captures 0x02,0x05,0x1F,0x01,0x0F in 500 cycles with no gaps. `cmd_valid_i` held high throughout sees no second acceptance.
- Illegal op=7 → `err_o` one-cycle pulse, `tx_o` stays 1, `frames_sent_o` unchanged, `cmd_ready_o` stays 1.
- Reset mid-frame: `rst_i` asserted during byte 2 of READ_PMU → `tx_o`=1 the next cycle. A following SET_DEPTH depth=0xA5 decodes cleanly as 0x01,0xA5.
- Wrap: preload `frames_sent_o` to 0xFFFF via force → one START frame sets it to 0x0000.
